// File: rtl/fifo_ctrl_ext.sv
// fifo_ctrl_ext: single-clock circular-buffer FIFO used as a per-port switch
// queue. Adds occupancy count, almost-full/almost-empty thresholds for
// arbiter back-pressure, synchronous flush and sticky overflow/underflow flags.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of contents (pointers, count)
//   wr_en, data_in      write request and data
//   rd_en               read request (pop); acknowledge in FWFT mode
//   data_out, rd_valid  read data and its qualifier
//   full, empty         count == DEPTH / count == 0
//   almost_full         count >= AF_LEVEL
//   almost_empty        count <= AE_LEVEL
//   count               occupancy 0..DEPTH
//   overflow, underflow sticky error flags, cleared by err_clr
module fifo_ctrl_ext #(
  parameter int DEPTH    = 64,
  parameter int W_WIDTH  = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [W_WIDTH-1:0] data_in,
  input  logic               rd_en,
  input  logic               err_clr,
  output logic [W_WIDTH-1:0] data_out,
  output logic               rd_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [AW:0]        count,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [AW:0] LP_FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AF_CNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] LP_AE_CNT   = (AW+1)'(AE_LEVEL);

  logic [W_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_overflow;
  logic               r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_set;
  logic w_unf_set;

  assign w_full  = (r_count == LP_FULL_CNT);
  assign w_empty = (r_count == '0);

  // Each side is judged on the pre-edge state only, so wr+rd while full
  // accepts just the read and wr+rd while empty accepts just the write.
  // Flush masks both requests, including their error reporting.
  assign w_wr_acc  = wr_en & ~w_full  & ~flush;
  assign w_rd_acc  = rd_en & ~w_empty & ~flush;
  assign w_ovf_set = wr_en &  w_full  & ~flush;
  assign w_unf_set = rd_en &  w_empty & ~flush;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + (AW+1)'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - (AW+1)'(1);
    end
  end

  // A new error in the same cycle as err_clr takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)    r_overflow  <= 1'b1;
      else if (err_clr) r_overflow  <= 1'b0;
      if (w_unf_set)    r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [W_WIDTH-1:0] r_data_out;
      logic               r_rd_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data_out <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
        end
      end

      assign data_out = r_data_out;
      assign rd_valid = r_rd_valid;
    end else begin : g_fwft_read
      // Memory is not reset, so the head word is forced to zero while empty;
      // this keeps data_out at zero during and right after reset.
      assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
      assign rd_valid = ~w_empty;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AF_CNT);
  assign almost_empty = (r_count <= LP_AE_CNT);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl_ext.sv
module tb_fifo_ctrl_ext;

  localparam int DEPTH = 8;
  localparam int AFL   = DEPTH - 4;
  localparam int AEL   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] d0_dout, d1_dout;
  logic       d0_rdv, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic       d1_rdv, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [3:0] d0_count, d1_count;

  fifo_ctrl_ext #(.DEPTH(DEPTH), .W_WIDTH(8), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .err_clr(err_clr), .data_out(d0_dout), .rd_valid(d0_rdv),
    .full(d0_full), .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
    .count(d0_count), .overflow(d0_ovf), .underflow(d0_unf)
  );

  fifo_ctrl_ext #(.DEPTH(DEPTH), .W_WIDTH(8), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .err_clr(err_clr), .data_out(d1_dout), .rd_valid(d1_rdv),
    .full(d1_full), .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
    .count(d1_count), .overflow(d1_ovf), .underflow(d1_unf)
  );

  always #5 clk = ~clk;

  // reference model: a queue of words plus flags
  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rdv0;
  logic [7:0] m_dout0;

  int    n_vec = 0;
  int    n_err = 0;
  string g_tag = "reset";

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: actual 0x%0h required 0x%0h", g_tag, name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_rdv0 = 0; m_dout0 = 8'h00;
  endtask

  task automatic model_step(bit f, bit w, bit r, bit c, logic [7:0] d);
    bit fl, em;
    if (f) begin
      q.delete();
      m_rdv0 = 0;
      if (c) begin m_ovf = 0; m_unf = 0; end
      return;
    end
    fl = (q.size() == DEPTH);
    em = (q.size() == 0);
    if (r && !em) begin m_dout0 = q.pop_front(); m_rdv0 = 1; end
    else m_rdv0 = 0;
    if (w && !fl) q.push_back(d);
    if (w && fl) m_ovf = 1; else if (c) m_ovf = 0;
    if (r && em) m_unf = 1; else if (c) m_unf = 0;
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count0", d0_count, sz);
    chk("full0", d0_full, sz == DEPTH);
    chk("empty0", d0_empty, sz == 0);
    chk("af0", d0_af, sz >= AFL);
    chk("ae0", d0_ae, sz <= AEL);
    chk("ovf0", d0_ovf, m_ovf);
    chk("unf0", d0_unf, m_unf);
    chk("rdv0", d0_rdv, m_rdv0);
    chk("dout0", d0_dout, m_dout0);
    chk("count1", d1_count, sz);
    chk("full1", d1_full, sz == DEPTH);
    chk("empty1", d1_empty, sz == 0);
    chk("ovf1", d1_ovf, m_ovf);
    chk("unf1", d1_unf, m_unf);
    chk("rdv1", d1_rdv, sz != 0);
    if (sz != 0) chk("dout1", d1_dout, q[0]);
  endtask

  task automatic cyc(bit f, bit w, bit r, bit c, logic [7:0] d);
    @(negedge clk);
    flush = f; wr_en = w; rd_en = r; err_clr = c; data_in = d;
    @(posedge clk);
    model_step(f, w, r, c, d);
    #1;
    check_all();
  endtask

  task automatic fill_to(int n);
    while (q.size() < n) cyc(0, 1, 0, 0, 8'($urandom));
  endtask

  task automatic drain();
    while (q.size() > 0) cyc(0, 0, 1, 0, 8'h00);
  endtask

  typedef struct {
    bit         f, w, r, c;
    logic [7:0] d;
    int         cnt;
    bit         full, empty, af, ae;
    logic [7:0] dout;
    bit         rdv;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // fill/drain table: 0x01..0x08 in, then 8 reads, then one idle cycle
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{f:0, w:1, r:0, c:0, d:8'(i + 1), cnt:i + 1, full:(i == 7),
                 empty:0, af:(i + 1 >= 4), ae:(i + 1 <= 4), dout:8'h00, rdv:0};
    end
    for (int i = 0; i < 8; i++) begin
      tbl[8 + i] = '{f:0, w:0, r:1, c:0, d:8'h00, cnt:7 - i, full:0,
                     empty:(i == 7), af:(7 - i >= 4), ae:(7 - i <= 4),
                     dout:8'(i + 1), rdv:1};
    end
    tbl[16] = '{f:0, w:0, r:0, c:0, d:8'h00, cnt:0, full:0, empty:1, af:0,
                ae:1, dout:8'h08, rdv:0};

    model_reset();
    #12;
    chk("rst count", d0_count, 0);
    chk("rst empty", d0_empty, 1);
    chk("rst full", d0_full, 0);
    chk("rst ae", d0_ae, 1);
    chk("rst af", d0_af, 0);
    chk("rst dout0", d0_dout, 0);
    chk("rst rdv0", d0_rdv, 0);
    chk("rst dout1", d1_dout, 0);
    chk("rst rdv1", d1_rdv, 0);
    chk("rst ovf", d0_ovf, 0);
    chk("rst unf", d0_unf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    g_tag = "table";
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].f, tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
      chk($sformatf("v%0d count", i), d0_count, tbl[i].cnt);
      chk($sformatf("v%0d full", i), d0_full, tbl[i].full);
      chk($sformatf("v%0d empty", i), d0_empty, tbl[i].empty);
      chk($sformatf("v%0d af", i), d0_af, tbl[i].af);
      chk($sformatf("v%0d ae", i), d0_ae, tbl[i].ae);
      chk($sformatf("v%0d rdv", i), d0_rdv, tbl[i].rdv);
      if (tbl[i].rdv || i == 16) chk($sformatf("v%0d dout", i), d0_dout, tbl[i].dout);
    end

    g_tag = "wrap";
    fill_to(6);
    drain();
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 8'(8'hA0 + i));
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0, 8'h00);
      chk($sformatf("wrap dout%0d", i), d0_dout, 8'hA0 + i);
      chk($sformatf("wrap rdv%0d", i), d0_rdv, 1);
    end
    chk("wrap count", d0_count, 0);

    g_tag = "simul";
    fill_to(3);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 0, 8'(8'hC0 + i));
      chk($sformatf("simul count%0d", i), d0_count, 3);
    end
    fill_to(8);
    cyc(0, 1, 1, 0, 8'hEE);
    chk("full wr+rd count", d0_count, 7);
    chk("full wr+rd ovf", d0_ovf, 1);
    drain();
    cyc(0, 1, 1, 0, 8'h3C);
    chk("empty wr+rd count", d0_count, 1);
    chk("empty wr+rd unf", d0_unf, 1);

    g_tag = "errflags";
    cyc(0, 0, 0, 1, 8'h00);
    chk("clr ovf", d0_ovf, 0);
    chk("clr unf", d0_unf, 0);
    fill_to(8);
    cyc(0, 1, 0, 0, 8'h99);
    chk("ovf set", d0_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'($urandom), 1'($urandom), 0, 8'($urandom));
      chk($sformatf("ovf sticky%0d", i), d0_ovf, 1);
    end
    cyc(0, 0, 0, 1, 8'h00);
    chk("ovf cleared", d0_ovf, 0);
    drain();
    cyc(0, 0, 1, 1, 8'h00);
    chk("unf wins clr", d0_unf, 1);

    g_tag = "fwft";
    cyc(0, 1, 0, 0, 8'h55);
    chk("fwft dout", d1_dout, 8'h55);
    chk("fwft rdv", d1_rdv, 1);
    cyc(0, 0, 1, 0, 8'h00);
    chk("fwft rdv after ack", d1_rdv, 0);
    chk("fwft empty after ack", d1_empty, 1);

    g_tag = "flush";
    fill_to(8);
    cyc(0, 1, 0, 0, 8'h11);
    cyc(1, 0, 0, 0, 8'h00);
    chk("flush count", d0_count, 0);
    fill_to(5);
    cyc(1, 1, 0, 0, 8'h77);
    chk("flush+wr count", d0_count, 0);
    chk("flush+wr empty", d0_empty, 1);
    chk("flush+wr ovf kept", d0_ovf, 1);
    chk("flush+wr rdv", d0_rdv, 0);

    g_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      int pw, pr;
      bit f, c;
      pw = ((i / 200) % 2 == 0) ? 75 : 30;
      pr = 105 - pw;
      f = ($urandom_range(63) == 0);
      c = !f && ($urandom_range(15) == 0);
      cyc(f, $urandom_range(99) < pw, $urandom_range(99) < pr, c, 8'($urandom));
    end

    g_tag = "async_rst";
    fill_to(8);
    cyc(0, 1, 0, 0, 8'h42);
    fill_to(5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst count", d0_count, 0);
    chk("arst empty", d0_empty, 1);
    chk("arst full", d0_full, 0);
    chk("arst ae", d0_ae, 1);
    chk("arst af", d0_af, 0);
    chk("arst dout0", d0_dout, 0);
    chk("arst rdv0", d0_rdv, 0);
    chk("arst ovf", d0_ovf, 0);
    chk("arst unf", d0_unf, 0);
    chk("arst dout1", d1_dout, 0);
    chk("arst rdv1", d1_rdv, 0);
    chk("arst count1", d1_count, 0);
    @(negedge clk);
    flush = 0; wr_en = 0; rd_en = 0; err_clr = 0;
    rst_n = 1'b1;
    cyc(0, 1, 0, 0, 8'h5A);
    cyc(0, 0, 1, 0, 8'h00);
    chk("post rst dout", d0_dout, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
